memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  Pipeline stage directly downstream of execute. Consumes the execute output register, waits for the
//  data-RAM response, aligns and extends load data, and drives the write-back register. Also holds the
//  HI/LO registers written by multiply/divide completion. Each execute-register entry commits exactly
//  once, even while execute is stalled.
// PARAMETERS
//  WAIT_CNT_W   8   width of the saturating data-wait performance counter
// PORTS
//  clk               in   1   clock
//  resetn            in   1   reset, asynchronous, active-low
//  exe_stop          in   1   execute stall; execute output register holds its contents
//  exe_reg_en        in   1   entry writes the register file
//  exe_mem_en        in   1   entry has an outstanding data-RAM access (load or store)
//  exe_mem_read      in   1   access is a load
//  exe_reg_waddr     in   5   destination register
//  alu_result_reg    in   32  result, or memory byte address
//  exe_load_type     in   3   LW=0 LB=1 LBU=2 LH=3 LHU=4 LWL=5 LWR=6
//  exe_load_rt_data  in   32  old rt value, used for merge by LWL/LWR
//  exe_MD_complete   in   1   multiply/divide result valid this cycle
//  exe_MD_result     in   64  {hi,lo}; for divide this is {remainder,quotient}
//  data_data_ok      in   1   data-RAM response valid this cycle
//  data_rdata        in   32  data-RAM read data
//  mem_reg_en        out  1   write-back register enable
//  mem_reg_waddr     out  5   write-back destination
//  mem_reg_wdata     out  32  write-back data
//  mem_busy          out  1   state==WAIT_DATA
//  hi, lo            out  32  HI/LO registers
//  mem_wait_cnt      out  WAIT_CNT_W  saturating count of WAIT_DATA cycles
// BEHAVIOUR
//  FSM states IDLE, WAIT_DATA, HELD. Reset: IDLE; all outputs 0.
//  commit = (state!=HELD) & (~exe_mem_en | data_data_ok).
//  On commit, at the clock edge:
//   - mem_reg_en    <= exe_reg_en & ~(exe_mem_en & ~exe_mem_read)   (stores never write)
//   - mem_reg_waddr <= exe_reg_waddr
//   - mem_reg_wdata <= aligned load data if exe_mem_read, else alu_result_reg
//   - next state    <= HELD if exe_stop, else IDLE
//  No commit: mem_reg_en <= 0 (bubble); waddr/wdata hold their values.
//  Transitions:
//   - IDLE/WAIT_DATA -> WAIT_DATA when exe_mem_en & ~data_data_ok
//   - HELD -> IDLE when ~exe_stop
//  Latency: one cycle from commit condition to mem_reg_* valid. Load latency = RAM latency + 1.
//  Alignment uses a = alu_result_reg[1:0]; memory is little-endian.
//   - LW:  rdata
//   - LB/LBU: byte a, sign-/zero-extended
//   - LH/LHU: half a[1], sign-/zero-extended
//   - LWL: a=0 {rd[7:0],rt[23:0]}; 1 {rd[15:0],rt[15:0]}; 2 {rd[23:0],rt[7:0]}; 3 rd
//   - LWR: a=0 rd; 1 {rt[31:24],rd[31:8]}; 2 {rt[31:16],rd[31:16]}; 3 {rt[31:8],rd[31:24]}
//  HI/LO: on exe_MD_complete, hi<=result[63:32], lo<=result[31:0]. Independent of FSM and exe_stop.
//  Boundary cases:
//   - data_data_ok while exe_mem_en=0: ignored.
//   - data_data_ok and exe_stop together: commit, then HELD (no duplicate write).
//   - mem_wait_cnt increments each WAIT_DATA cycle and saturates at all-ones.
//   - resetn low mid-wait: immediate IDLE, outputs cleared; a late data_data_ok after reset is ignored
//     unless exe_mem_en is high.
// CONFIGURATION
//  MEM_STAGE_FWD_EN defined: adds outputs
//   - mem_fwd_valid (1) = exe_reg_en & (~exe_mem_read | (exe_mem_en & data_data_ok)) & state!=HELD
//   - mem_fwd_waddr (5) = exe_reg_waddr
//   - mem_fwd_wdata (32) = next mem_reg_wdata
//  These are combinational forwarding outputs for the hazard unit.
//  Undefined: the ports are absent; the hazard unit forwards from mem_reg_* only.
// TESTING
//  ALU entry exe_reg_en=1 waddr=5 alu=0x1234, exe_stop=0 -> next cycle mem_reg_en=1 waddr=5 wdata=0x1234
//  LB a=3, data_ok after 3 cycles, rdata=0x80FFFFFF -> wdata=0xFFFFFF80 one cycle after ok; mem_busy=1
//   for 3 cycles; mem_wait_cnt=3
//  LWR a=2 rt=0xAABBCCDD rdata=0x11223344 -> wdata=0xAABB1122
//  LWL a=1 rt=0xAABBCCDD rdata=0x11223344 -> wdata=0x3344CCDD
//  Load commits with exe_stop=1 held 4 cycles -> exactly one mem_reg_en pulse, then bubbles, then IDLE
//  exe_MD_complete with result 0x00000007_00000003 -> hi=7 lo=3 next cycle; resetn pulse mid-WAIT_DATA
//   -> all outputs 0, state IDLE

Source files
------------

// File: rtl/memory_stage_if.sv
// Execute-to-memory bundle: execute register, data-RAM response and
// memory-stage outputs; MEM_STAGE_FWD_EN adds the forwarding outputs.
interface memory_stage_if #(
  parameter int WAIT_CNT_W = 8
);
  logic        exe_stop;
  logic        exe_reg_en;
  logic        exe_mem_en;
  logic        exe_mem_read;
  logic [4:0]  exe_reg_waddr;
  logic [31:0] alu_result_reg;
  logic [2:0]  exe_load_type;
  logic [31:0] exe_load_rt_data;
  logic        exe_MD_complete;
  logic [63:0] exe_MD_result;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_reg_en;
  logic [4:0]  mem_reg_waddr;
  logic [31:0] mem_reg_wdata;
  logic        mem_busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [WAIT_CNT_W-1:0] mem_wait_cnt;
`ifdef MEM_STAGE_FWD_EN
  logic        mem_fwd_valid;
  logic [4:0]  mem_fwd_waddr;
  logic [31:0] mem_fwd_wdata;
`endif

  modport master (
`ifdef MEM_STAGE_FWD_EN
    input  mem_fwd_valid, mem_fwd_waddr,
    input  mem_fwd_wdata,
`endif
    output exe_stop, exe_reg_en, exe_mem_en,
    output exe_mem_read, exe_reg_waddr,
    output alu_result_reg, exe_load_type,
    output exe_load_rt_data,
    output exe_MD_complete, exe_MD_result,
    output data_data_ok, data_rdata,
    input  mem_reg_en, mem_reg_waddr,
    input  mem_reg_wdata, mem_busy,
    input  hi, lo, mem_wait_cnt
  );

  modport slave (
`ifdef MEM_STAGE_FWD_EN
    output mem_fwd_valid, mem_fwd_waddr,
    output mem_fwd_wdata,
`endif
    input  exe_stop, exe_reg_en, exe_mem_en,
    input  exe_mem_read, exe_reg_waddr,
    input  alu_result_reg, exe_load_type,
    input  exe_load_rt_data,
    input  exe_MD_complete, exe_MD_result,
    input  data_data_ok, data_rdata,
    output mem_reg_en, mem_reg_waddr,
    output mem_reg_wdata, mem_busy,
    output hi, lo, mem_wait_cnt
  );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: waits on data RAM, aligns loads, drives write-back, holds HI/LO.
// Optional MEM_STAGE_FWD_EN exposes combinational forwarding outputs.
module memory_stage #(
  parameter int WAIT_CNT_W = 8
) (
  input logic          clk,
  input logic          resetn,
  memory_stage_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    HELD      = 2'd2
  } state_e;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;
  localparam logic [2:0] LT_LWL = 3'd5;
  localparam logic [2:0] LT_LWR = 3'd6;

  state_e      state_q, state_d;
  logic        reg_en_q, reg_en_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  logic        commit;
  logic [1:0]  a;
  logic [31:0] rd;
  logic [31:0] rt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign a  = bus.alu_result_reg[1:0];
  assign rd = bus.data_rdata;
  assign rt = bus.exe_load_rt_data;

  // Little-endian byte/half select and LWL/LWR merge with old rt
  always_comb begin
    ld_byte = rd[7:0];
    ld_half = a[1] ? rd[31:16] : rd[15:0];
    ld_data = rd;
    case (a)
      2'd0: ld_byte = rd[7:0];
      2'd1: ld_byte = rd[15:8];
      2'd2: ld_byte = rd[23:16];
      default: ld_byte = rd[31:24];
    endcase
    case (bus.exe_load_type)
      LT_LW:  ld_data = rd;
      LT_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      LT_LBU: ld_data = {24'd0, ld_byte};
      LT_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      LT_LHU: ld_data = {16'd0, ld_half};
      LT_LWL: begin
        case (a)
          2'd0: ld_data = {rd[7:0], rt[23:0]};
          2'd1: ld_data = {rd[15:0], rt[15:0]};
          2'd2: ld_data = {rd[23:0], rt[7:0]};
          default: ld_data = rd;
        endcase
      end
      LT_LWR: begin
        case (a)
          2'd0: ld_data = rd;
          2'd1: ld_data = {rt[31:24], rd[31:8]};
          2'd2: ld_data = {rt[31:16], rd[31:16]};
          default: ld_data = {rt[31:8], rd[31:24]};
        endcase
      end
      default: ld_data = rd;
    endcase
  end

  // Commit once per entry; HELD blocks re-commit while execute stalls
  always_comb begin
    commit  = (state_q != HELD)
            & (~bus.exe_mem_en | bus.data_data_ok);
    state_d = state_q;
    reg_en_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (commit) begin
      reg_en_d = bus.exe_reg_en
               & ~(bus.exe_mem_en & ~bus.exe_mem_read);
      waddr_d  = bus.exe_reg_waddr;
      wdata_d  = bus.exe_mem_read ? ld_data
                                  : bus.alu_result_reg;
      state_d  = bus.exe_stop ? HELD : IDLE;
    end else if (state_q == HELD) begin
      state_d = bus.exe_stop ? HELD : IDLE;
    end else begin
      state_d = WAIT_DATA;
    end
  end

  // HI/LO capture and saturating wait counter
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (bus.exe_MD_complete) begin
      hi_d = bus.exe_MD_result[63:32];
      lo_d = bus.exe_MD_result[31:0];
    end
    if (state_q == WAIT_DATA && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
  end

  // State and output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      reg_en_q <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      reg_en_q <= reg_en_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.mem_reg_en    = reg_en_q;
  assign bus.mem_reg_waddr = waddr_q;
  assign bus.mem_reg_wdata = wdata_q;
  assign bus.mem_busy      = (state_q == WAIT_DATA);
  assign bus.hi            = hi_q;
  assign bus.lo            = lo_q;
  assign bus.mem_wait_cnt  = cnt_q;

`ifdef MEM_STAGE_FWD_EN
  assign bus.mem_fwd_valid = bus.exe_reg_en
    & (~bus.exe_mem_read
       | (bus.exe_mem_en & bus.data_data_ok))
    & (state_q != HELD);
  assign bus.mem_fwd_waddr = bus.exe_reg_waddr;
  assign bus.mem_fwd_wdata = wdata_d;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: every write-back pulse is popped
// from a queue of expected {waddr,wdata} pushed when the entry is driven.
module tb_memory_stage;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [36:0] sb_q[$];

  always #5 clk = ~clk;

  memory_stage_if #(.WAIT_CNT_W(8)) bus();

  memory_stage #(.WAIT_CNT_W(8)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  // Every write-back pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (resetn && bus.mem_reg_en) begin
      logic [36:0] exp_e;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra got=%h_%h want=none",
                 bus.mem_reg_waddr, bus.mem_reg_wdata);
      end else begin
        exp_e = sb_q.pop_front();
        if ({bus.mem_reg_waddr, bus.mem_reg_wdata} !== exp_e) begin
          errors++;
          $display("FAIL sb_data got=%h_%h want=%h_%h",
                   bus.mem_reg_waddr, bus.mem_reg_wdata,
                   exp_e[36:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic drive_idle();
    bus.exe_stop = 0;
    bus.exe_reg_en = 0;
    bus.exe_mem_en = 0;
    bus.exe_mem_read = 0;
    bus.exe_reg_waddr = 0;
    bus.alu_result_reg = 0;
    bus.exe_load_type = 0;
    bus.exe_load_rt_data = 0;
    bus.exe_MD_complete = 0;
    bus.exe_MD_result = 0;
    bus.data_data_ok = 0;
    bus.data_rdata = 0;
  endtask

  task automatic drive_entry(input logic ren, input logic men,
                             input logic rdn, input logic [4:0] wa,
                             input logic [31:0] alu,
                             input logic [2:0] lt,
                             input logic [31:0] rt);
    bus.exe_reg_en = ren;
    bus.exe_mem_en = men;
    bus.exe_mem_read = rdn;
    bus.exe_reg_waddr = wa;
    bus.alu_result_reg = alu;
    bus.exe_load_type = lt;
    bus.exe_load_rt_data = rt;
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] lt,
                                             input logic [1:0] a,
                                             input logic [31:0] rd,
                                             input logic [31:0] rt);
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] m;
    b = (rd >> (8 * a)) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    m = 32'hFFFF_FFFF;
    case (lt)
      3'd1: return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd2: return b;
      3'd3: return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4: return h;
      3'd5: return (rd << (8 * (3 - a)))
                 | (rt & (m >> (8 * (a + 1))));
      3'd6: return (rd >> (8 * a)) | (rt & ~(m >> (8 * a)));
      default: return rd;
    endcase
  endfunction

  task automatic test_reset();
    drive_idle();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.mem_reg_en, bus.mem_reg_waddr, bus.mem_reg_wdata,
         bus.mem_busy, bus.hi, bus.lo, bus.mem_wait_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got en=%b busy=%b cnt=%0d want=0",
               bus.mem_reg_en, bus.mem_busy, bus.mem_wait_cnt);
    end
    @(negedge clk);
    resetn = 1;
  endtask

  task automatic test_alu();
    @(posedge clk); #1;
    drive_entry(1, 0, 0, 5'd5, 32'h1234, 3'd0, 0);
    sb_q.push_back({5'd5, 32'h1234});
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_reg_en, bus.mem_reg_waddr, bus.mem_reg_wdata}
        !== {1'b1, 5'd5, 32'h1234}) begin
      errors++;
      $display("FAIL alu got=%b_%h_%h want=1_05_00001234",
               bus.mem_reg_en, bus.mem_reg_waddr, bus.mem_reg_wdata);
    end
    // data_ok with no memory access must be ignored
    drive_entry(1, 0, 0, 5'd6, 32'hBEEF, 3'd0, 0);
    bus.data_data_ok = 1;
    bus.data_rdata = 32'h5555_AAAA;
    sb_q.push_back({5'd6, 32'hBEEF});
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    checks++;
    if (bus.mem_reg_en !== 1'b0) begin
      errors++;
      $display("FAIL alu_bubble got=%b want=0", bus.mem_reg_en);
    end
  endtask

  task automatic test_lb_wait();
    int busy_n;
    logic [7:0] cnt0;
    busy_n = 0;
    cnt0 = bus.mem_wait_cnt;
    @(posedge clk); #1;
    drive_entry(1, 1, 1, 5'd7, 32'h103, 3'd1, 0);
    sb_q.push_back({5'd7, 32'hFFFF_FF80});
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (bus.mem_busy) busy_n++;
      if (i == 1) begin
        bus.exe_MD_complete = 1;
        bus.exe_MD_result = 64'h0000_0007_0000_0003;
      end else begin
        bus.exe_MD_complete = 0;
      end
    end
    bus.data_data_ok = 1;
    bus.data_rdata = 32'h80FF_FFFF;
    @(posedge clk); #1;
    checks++;
    if (busy_n != 3) begin
      errors++;
      $display("FAIL lb_busy got=%0d want=3", busy_n);
    end
    checks++;
    if (bus.mem_wait_cnt - cnt0 !== 8'd3) begin
      errors++;
      $display("FAIL lb_waitcnt got=%0d want=3",
               bus.mem_wait_cnt - cnt0);
    end
    checks++;
    if ({bus.mem_reg_en, bus.mem_reg_wdata, bus.mem_busy}
        !== {1'b1, 32'hFFFF_FF80, 1'b0}) begin
      errors++;
      $display("FAIL lb_data got=%b_%h_%b want=1_ffffff80_0",
               bus.mem_reg_en, bus.mem_reg_wdata, bus.mem_busy);
    end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0007_0000_0003) begin
      errors++;
      $display("FAIL md_in_wait got=%h_%h want=7_3", bus.hi, bus.lo);
    end
    drive_idle();
  endtask

  task automatic test_lwl_lwr();
    @(posedge clk); #1;
    drive_entry(1, 1, 1, 5'd10, 32'h2, 3'd6, 32'hAABB_CCDD);
    bus.data_data_ok = 1;
    bus.data_rdata = 32'h1122_3344;
    sb_q.push_back({5'd10, 32'hAABB_1122});
    @(posedge clk); #1;
    checks++;
    if (bus.mem_reg_wdata !== 32'hAABB_1122) begin
      errors++;
      $display("FAIL lwr got=%h want=aabb1122", bus.mem_reg_wdata);
    end
    drive_entry(1, 1, 1, 5'd11, 32'h1, 3'd5, 32'hAABB_CCDD);
    sb_q.push_back({5'd11, 32'h3344_CCDD});
    @(posedge clk); #1;
    checks++;
    if (bus.mem_reg_wdata !== 32'h3344_CCDD) begin
      errors++;
      $display("FAIL lwl got=%h want=3344ccdd", bus.mem_reg_wdata);
    end
    drive_idle();
  endtask

  task automatic test_align_random();
    logic [2:0]  lt;
    logic [31:0] alu, rt, rd;
    @(posedge clk); #1;
    for (int i = 0; i < 24; i++) begin
      lt  = 3'($urandom_range(0, 6));
      alu = $urandom;
      rt  = $urandom;
      rd  = $urandom;
      drive_entry(1, 1, 1, 5'(i + 1), alu, lt, rt);
      bus.data_data_ok = 1;
      bus.data_rdata = rd;
      sb_q.push_back({5'(i + 1), model_load(lt, alu[1:0], rd, rt)});
      @(posedge clk); #1;
    end
    drive_idle();
  endtask

  task automatic test_store();
    @(posedge clk); #1;
    drive_entry(1, 1, 0, 5'd12, 32'h40, 3'd0, 0);
    bus.data_data_ok = 1;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_reg_en !== 1'b0) begin
      errors++;
      $display("FAIL store_write got=%b want=0", bus.mem_reg_en);
    end
    drive_idle();
  endtask

  task automatic test_stop_held();
    int pulses;
    pulses = 0;
    @(posedge clk); #1;
    drive_entry(1, 1, 1, 5'd9, 32'h0, 3'd0, 0);
    bus.exe_stop = 1;
    bus.data_data_ok = 1;
    bus.data_rdata = 32'hCAFE_F00D;
    sb_q.push_back({5'd9, 32'hCAFE_F00D});
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      if (bus.mem_reg_en) pulses++;
      if (i == 1) bus.data_data_ok = 0;
      if (i == 4) drive_idle();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL stop_pulses got=%0d want=1", pulses);
    end
    drive_entry(1, 0, 0, 5'd13, 32'h77, 3'd0, 0);
    sb_q.push_back({5'd13, 32'h77});
    @(posedge clk); #1;
    checks++;
    if (bus.mem_reg_en !== 1'b1) begin
      errors++;
      $display("FAIL stop_to_idle got=%b want=1", bus.mem_reg_en);
    end
    drive_idle();
  endtask

  task automatic test_md();
    @(posedge clk); #1;
    bus.exe_stop = 1;
    bus.exe_MD_complete = 1;
    bus.exe_MD_result = 64'h0000_00AB_0000_00CD;
    @(posedge clk); #1;
    drive_idle();
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_00AB_0000_00CD) begin
      errors++;
      $display("FAIL md got=%h_%h want=ab_cd", bus.hi, bus.lo);
    end
    @(posedge clk); #1;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_00AB_0000_00CD) begin
      errors++;
      $display("FAIL md_hold got=%h_%h want=ab_cd", bus.hi, bus.lo);
    end
  endtask

  task automatic test_saturate();
    @(posedge clk); #1;
    drive_entry(1, 1, 1, 5'd14, 32'h0, 3'd0, 0);
    repeat (262) @(posedge clk);
    #1;
    checks++;
    if (bus.mem_wait_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL sat got=%0d want=255", bus.mem_wait_cnt);
    end
    bus.data_data_ok = 1;
    bus.data_rdata = 32'h0BAD_CAFE;
    sb_q.push_back({5'd14, 32'h0BAD_CAFE});
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    checks++;
    if ({bus.mem_wait_cnt, bus.mem_busy} !== {8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL sat_hold got=%0d_%b want=255_0",
               bus.mem_wait_cnt, bus.mem_busy);
    end
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); #1;
    drive_entry(1, 1, 1, 5'd15, 32'h0, 3'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 0;
    #1;
    checks++;
    if ({bus.mem_reg_en, bus.mem_reg_waddr, bus.mem_reg_wdata,
         bus.mem_busy, bus.hi, bus.lo, bus.mem_wait_cnt} !== '0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b cnt=%0d hi=%h want=0",
               bus.mem_busy, bus.mem_wait_cnt, bus.hi);
    end
    drive_idle();
    @(negedge clk);
    resetn = 1;
    bus.data_data_ok = 1;
    bus.data_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.data_data_ok = 0;
    checks++;
    if ({bus.mem_reg_en, bus.mem_busy, bus.mem_reg_wdata}
        !== {1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL late_ok got=%b_%b_%h want=0_0_0",
               bus.mem_reg_en, bus.mem_busy, bus.mem_reg_wdata);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_wait();
    test_lwl_lwr();
    test_align_random();
    test_store();
    test_stop_held();
    test_md();
    test_saturate();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_left got=%0d want=0", sb_q.size());
    end
    test_reset_mid_wait();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
